// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the memory responder slice:
//   - data / byte-enable / wait-counter widths
//   - FSM state encoding
//   - byte_merge(): applies a byte-enable mask to a stored word
// -----------------------------------------------------------------------------
package mem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;   // holds WAIT_CYCLES-1 for WAIT_CYCLES up to 15

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be_mask
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be_mask[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_responder_dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word-organised storage for mem_responder. Contents are not reset.
// Ports:
//   clk      : clock
//   we_i     : write strobe, commits on the rising edge
//   waddr_i  : write word index
//   wdata_i  : write data
//   be_i     : byte enables for the write (be_i[i] -> wdata_i[8i+7:8i])
//   raddr_i  : read word index
//   rdata_o  : read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module dmem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= byte_merge(mem_q[waddr_i], wdata_i, be_i);
    end
  end

  // Asynchronous read so the response can be presented in the RESP cycle
  // even when there are no wait states.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Single-outstanding memory responder with a programmable number of wait
// states ahead of each one-cycle response.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready=1, waiting for req; request fields latched on accept
// ST_WAIT | counting down wait states, request ignored
// ST_RESP | rvalid=1 for one cycle; writes commit at the end of it
//
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   req    : request valid
//   we     : 1 = write, 0 = read
//   addr   : byte address (word aligned accesses only)
//   wdata  : write data
//   be     : write byte enables
//   ready  : request accepted this cycle when req is also high
//   rvalid : one-cycle response strobe
//   rdata  : read data, zero unless a good read response
//   err    : misaligned or out-of-range access, qualified by rvalid
// -----------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic              accept;
  logic              in_resp;
  logic              addr_err;
  logic              mem_we;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] mem_rdata;

  assign ready   = (state_q == ST_IDLE);
  assign accept  = req & ready;
  assign in_resp = (state_q == ST_RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be;
      end
    end
  end

  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_LIM);
  assign word_idx = addr_q[IDX_W+1:2];

  // Reset in the RESP cycle suppresses the commit of a pending write.
  assign mem_we = in_resp & we_q & ~addr_err & ~rst;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_dmem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (word_idx),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .raddr_i (word_idx),
    .rdata_o (mem_rdata)
  );

  assign rvalid = in_resp;
  assign err    = in_resp & addr_err;
  assign rdata  = (in_resp & ~we_q & ~addr_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder. The main instance uses WAIT_CYCLES=2,
// a second instance uses WAIT_CYCLES=0 for the back-to-back throughput case.
// Expected responses are queued when a request is accepted and popped when
// rvalid is seen.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ready, rvalid, err;
  logic [31:0] rdata;

  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic        ready0, rvalid0, err0;
  logic [31:0] rdata0;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .be(be0), .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  logic [31:0] last_rdata;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed=timeout expected=response", tag);
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after accept.
  task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output int acc);
    chk("ready_before_accept", ready, 1'b1);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    chk("ready_low_after_accept", ready, 1'b0);
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input int acc);
    exp_t e;
    logic bad;
    bad   = addr_bad(a);
    e.err = bad;
    e.acc = acc;
    if (w) begin
      e.rdata = '0;
      if (!bad) begin
        for (int i = 0; i < 4; i++) begin
          if (b[i]) model[a[11:2]][8*i +: 8] = d[8*i +: 8];
        end
      end
    end else begin
      e.rdata = bad ? 32'h0 : model[a[11:2]];
    end
    sb.push_back(e);
  endtask

  task automatic collect();
    exp_t e;
    for (int i = 0; i < 30; i++) begin
      if (rvalid) break;
      @(negedge clk);
    end
    req = 1'b0;
    if (!rvalid) begin
      fail_now("rvalid_wait");
    end else if (sb.size() == 0) begin
      fail_now("scoreboard_empty");
    end else begin
      e = sb.pop_front();
      last_rdata = rdata;
      chk("resp_rdata", rdata, e.rdata);
      chk("resp_err", err, e.err);
      chk("resp_latency", cyc, e.acc + 1 + W);
      chk("ready_low_in_resp", ready, 1'b0);
      @(negedge clk);
      chk("rvalid_one_cycle", rvalid, 1'b0);
      chk("rdata_idle_zero", rdata, 32'h0);
      chk("err_idle_zero", err, 1'b0);
      chk("ready_after_resp", ready, 1'b1);
    end
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b);
    int acc;
    start(w, a, d, b, acc);
    push(w, a, d, b, acc);
    collect();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int pulses;
    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
    last_rdata = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset_ready", ready, 1'b1);
    chk("reset_rvalid", rvalid, 1'b0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_err", err, 1'b0);
    chk("reset_ready0", ready0, 1'b1);
    chk("reset_rvalid0", rvalid0, 1'b0);

    // Full-word write then read back
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    txn(1'b0, 32'h10, 32'h0, 4'hF);
    chk("full_word_readback", last_rdata, 32'hDEADBEEF);

    // Partial write on lanes 0 and 2
    txn(1'b1, 32'h10, 32'h11223344, 4'h5);
    txn(1'b0, 32'h10, 32'h0, 4'h0);
    chk("byte_mask_readback", last_rdata, 32'hDE22BE44);

    // be=0 write completes with no change
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
    txn(1'b0, 32'h10, 32'h0, 4'hF);

    // Error cases; 0x1000 aliases word 0 if range is not checked
    txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
    txn(1'b0, 32'h13, 32'h0, 4'hF);
    txn(1'b0, 32'h1000, 32'h0, 4'hF);
    txn(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF);
    txn(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
    txn(1'b0, 32'h10, 32'h0, 4'hF);
    chk("err_write_no_change_0x10", last_rdata, 32'hDE22BE44);
    txn(1'b0, 32'h0, 32'h0, 4'hF);
    chk("err_write_no_change_0x0", last_rdata, 32'hCAFEF00D);

    // Last valid word
    txn(1'b1, 32'hFFC, 32'h5A5AA5A5, 4'hF);
    txn(1'b0, 32'hFFC, 32'h0, 4'hF);

    // req held during WAIT/RESP must be ignored
    start(1'b0, 32'h10, 32'h0, 4'h0, acc);
    push(1'b0, 32'h10, 32'h0, 4'h0, acc);
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hFFFFFFFF; be = 4'hF;
    collect();
    txn(1'b0, 32'h10, 32'h0, 4'hF);

    // Reset during WAIT aborts the write
    txn(1'b1, 32'h20, 32'hAAAA5555, 4'hF);
    start(1'b1, 32'h20, 32'h12345678, 4'hF, acc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_ready", ready, 1'b1);
    chk("rst_wait_rvalid", rvalid, 1'b0);
    chk("rst_wait_rdata", rdata, 32'h0);
    chk("rst_wait_err", err, 1'b0);
    txn(1'b0, 32'h20, 32'h0, 4'hF);
    chk("rst_wait_old_data", last_rdata, 32'hAAAA5555);

    // Reset coinciding with the RESP cycle blocks the commit
    start(1'b1, 32'h20, 32'h0BADF00D, 4'hF, acc);
    for (int i = 0; i < 30; i++) begin
      if (rvalid) break;
      @(negedge clk);
    end
    if (!rvalid) fail_now("rst_resp_wait");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_resp_ready", ready, 1'b1);
    chk("rst_resp_rvalid", rvalid, 1'b0);
    txn(1'b0, 32'h20, 32'h0, 4'hF);
    chk("rst_resp_no_commit", last_rdata, 32'hAAAA5555);

    // Zero wait states, req held for 10 cycles
    @(negedge clk);
    pulses = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; wdata0 = 32'h600DCAFE; be0 = 4'hF;
    for (int i = 0; i < 10; i++) begin
      chk("b2b_ready", ready0, (i % 2) == 0);
      chk("b2b_rvalid", rvalid0, (i % 2) == 1);
      if (rvalid0) begin
        pulses++;
        chk("b2b_err", err0, 1'b0);
        chk("b2b_rdata", rdata0, 32'h0);
      end
      @(negedge clk);
    end
    req0 = 1'b0;
    chk("b2b_pulses", pulses, 5);
    @(negedge clk);
    chk("w0_ready_idle", ready0, 1'b1);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4;
    @(negedge clk);
    req0 = 1'b0;
    chk("w0_read_rvalid", rvalid0, 1'b1);
    chk("w0_read_rdata", rdata0, 32'h600DCAFE);
    chk("w0_read_err", err0, 1'b0);
    @(negedge clk);
    chk("w0_rvalid_drop", rvalid0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
